// File: rtl/pwm_pkg.sv
// Shared constants and types for the RC PWM capture and generator blocks.
package pwm_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned PWM_FRAME = 1_000_000;
    localparam int unsigned PULSE_MIN = 50_000;
    localparam int unsigned PULSE_MAX = 100_000;

    typedef enum logic [1:0] {
        ARM,
        WAIT_RISE,
        HIGH
    } capture_state_t;

    // True when a measured high time lies inside the accepted window (inclusive).
    function automatic logic in_range(input logic [31:0] cnt,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus registered
// rise/fall detection. Also used for the push-button input.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    // Fewer than two stages would not give metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              s_d;

    assign s = sync_q[STAGES-1];

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    // Delay the synchronized level by one flop and register the edge strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s_d  <= s;
            rise <= s & ~s_d;
            fall <= ~s & s_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Receive side of the servo/ESC PWM link: measures pulse high time and
// frame period, flags out-of-range pulses and loss of signal.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned MIN_WIDTH   = PULSE_MIN,
    parameter int unsigned MAX_WIDTH   = PULSE_MAX,
    parameter int unsigned TIMEOUT     = 1_250_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pwm_in,
    output logic [31:0] width,
    output logic        width_valid,
    output logic [31:0] period,
    output logic        range_error,
    output logic        signal_lost
);

    localparam logic [31:0] MIN_W  = MIN_WIDTH;
    localparam logic [31:0] MAX_W  = MAX_WIDTH;
    localparam logic [31:0] TO_W   = TIMEOUT;
    // The synchronizer pipeline holds reset zeros for this many cycles, so
    // ARM must not trust s=0 until it has drained; otherwise a pulse that is
    // already high at reset release would look like a fresh rising edge.
    localparam logic [31:0] SETTLE = 32'(SYNC_STAGES + 1);

    logic           s;
    logic           rise;
    logic           fall;

    capture_state_t state;
    capture_state_t state_next;

    logic [31:0]    hi_cnt;
    logic [31:0]    per_cnt;
    logic [31:0]    edge_cnt;
    logic [31:0]    settle_cnt;
    logic           have_rise;

    logic           settled;
    logic           timeout;
    logic           start_pulse;
    logic           accept;
    logic           reject;
    logic           arm_exit;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    assign settled = (settle_cnt >= SETTLE);

    // Next-state and per-cycle event decode; timeout outranks any edge.
    always_comb begin
        state_next  = state;
        start_pulse = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        arm_exit    = 1'b0;
        timeout     = (state != ARM) && (edge_cnt >= TO_W);
        if (timeout) begin
            state_next = ARM;
        end else begin
            case (state)
                ARM: begin
                    if (settled && !s) begin
                        state_next = WAIT_RISE;
                        arm_exit   = 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_next  = HIGH;
                        start_pulse = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = WAIT_RISE;
                        if (in_range(hi_cnt, MIN_W, MAX_W)) begin
                            accept = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ARM;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    // Counters that time the pulse, the frame and the gap since the last edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt     <= '0;
            per_cnt    <= '0;
            edge_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            if (!settled) begin
                settle_cnt <= settle_cnt + 32'd1;
            end

            if (start_pulse) begin
                hi_cnt <= 32'd1;
            end else if (state == HIGH) begin
                hi_cnt <= hi_cnt + 32'd1;
            end

            if (start_pulse) begin
                per_cnt <= 32'd1;
            end else if (have_rise && (state != ARM)) begin
                per_cnt <= per_cnt + 32'd1;
            end

            // Arming restarts the loss timer so a stale count from a long
            // held-high line cannot fire the instant ARM hands over.
            if (rise || fall || arm_exit) begin
                edge_cnt <= '0;
            end else if (edge_cnt < TO_W) begin
                edge_cnt <= edge_cnt + 32'd1;
            end
        end
    end

    // Reported results, strobes and the loss-of-signal level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            width       <= '0;
            period      <= '0;
            width_valid <= 1'b0;
            range_error <= 1'b0;
            signal_lost <= 1'b1;
            have_rise   <= 1'b0;
        end else begin
            width_valid <= accept;
            range_error <= reject;

            if (accept) begin
                width       <= hi_cnt;
                signal_lost <= 1'b0;
            end

            if (start_pulse) begin
                if (have_rise) begin
                    period <= per_cnt;
                end
                have_rise <= 1'b1;
            end

            if (timeout) begin
                signal_lost <= 1'b1;
                have_rise   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture, run with the timing constants scaled down
// by 100 (500..1000 cycle pulses, 10000-cycle frames, 12500-cycle timeout).
module tb_pwm_capture;

    localparam int MIN_W   = 500;
    localparam int MAX_W   = 1000;
    localparam int TO      = 12500;
    localparam int FRAME   = 10000;

    logic        clock;
    logic        reset_n;
    logic        pwm_in;
    logic [31:0] width;
    logic        width_valid;
    logic [31:0] period;
    logic        range_error;
    logic        signal_lost;

    int vector_count = 0;
    int miss_count   = 0;
    int wv_count     = 0;
    int re_count     = 0;
    int both_count   = 0;
    int wv_before;
    int re_before;

    pwm_capture #(
        .MIN_WIDTH  (MIN_W),
        .MAX_WIDTH  (MAX_W),
        .TIMEOUT    (TO),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .width      (width),
        .width_valid(width_valid),
        .period     (period),
        .range_error(range_error),
        .signal_lost(signal_lost)
    );

    // 50 MHz clock.
    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Tally strobes sampled away from the active edge.
    always @(negedge clock) begin
        if (width_valid) wv_count++;
        if (range_error) re_count++;
        if (width_valid && range_error) both_count++;
    end

    // Keep the run from hanging if something stalls.
    initial begin
        #(200000 * 20);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one pulse starting at the current negedge: high then low cycles.
    task automatic applyStimulus(input int high_cycles, input int low_cycles);
        pwm_in = 1'b1;
        repeat (high_cycles) @(negedge clock);
        pwm_in = 1'b0;
        repeat (low_cycles) @(negedge clock);
    endtask

    task automatic snapshot();
        wv_before = wv_count;
        re_before = re_count;
    endtask

    initial begin
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst width", width, 32'd0);
        checkOutput("rst period", period, 32'd0);
        checkOutput("rst width_valid", {31'd0, width_valid}, 32'd0);
        checkOutput("rst range_error", {31'd0, range_error}, 32'd0);
        checkOutput("rst signal_lost", {31'd0, signal_lost}, 32'd1);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        // Nominal 750-cycle pulses in 10000-cycle frames, with strobe latency.
        $display("[TB] nominal frames");
        snapshot();
        pwm_in = 1'b1;
        repeat (750) @(negedge clock);
        pwm_in = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("valid early", {31'd0, width_valid}, 32'd0);
        @(negedge clock);
        checkOutput("valid at fall+4", {31'd0, width_valid}, 32'd1);
        checkOutput("width 750", width, 32'd750);
        @(negedge clock);
        checkOutput("valid one cycle", {31'd0, width_valid}, 32'd0);
        checkOutput("lost cleared", {31'd0, signal_lost}, 32'd0);
        repeat (FRAME - 750 - 5) @(negedge clock);
        applyStimulus(750, FRAME - 750);
        checkOutput("period frame2", period, FRAME);
        applyStimulus(750, 1500);
        checkOutput("period frame3", period, FRAME);
        checkOutput("width frame3", width, 32'd750);
        checkOutput("valid count frames", 32'(wv_count - wv_before), 32'd3);

        // Boundary pulse widths.
        $display("[TB] boundary widths");
        snapshot();
        applyStimulus(MIN_W - 1, 1500);
        checkOutput("499 range_error", 32'(re_count - re_before), 32'd1);
        checkOutput("499 no valid", 32'(wv_count - wv_before), 32'd0);
        checkOutput("499 width held", width, 32'd750);
        snapshot();
        applyStimulus(MIN_W, 1500);
        checkOutput("500 valid", 32'(wv_count - wv_before), 32'd1);
        checkOutput("500 width", width, 32'd500);
        snapshot();
        applyStimulus(MAX_W, 1500);
        checkOutput("1000 valid", 32'(wv_count - wv_before), 32'd1);
        checkOutput("1000 width", width, 32'd1000);
        snapshot();
        applyStimulus(MAX_W + 1, 1500);
        checkOutput("1001 range_error", 32'(re_count - re_before), 32'd1);
        checkOutput("1001 no valid", 32'(wv_count - wv_before), 32'd0);
        checkOutput("1001 width held", width, 32'd1000);

        // Reset asserted mid-pulse and released while the input is still high.
        $display("[TB] reset mid-pulse");
        pwm_in = 1'b1;
        repeat (300) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("async rst width", width, 32'd0);
        checkOutput("async rst period", period, 32'd0);
        checkOutput("async rst lost", {31'd0, signal_lost}, 32'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        snapshot();
        repeat (700) @(negedge clock);
        pwm_in = 1'b0;
        repeat (1500) @(negedge clock);
        checkOutput("partial no valid", 32'(wv_count - wv_before), 32'd0);
        checkOutput("partial no error", 32'(re_count - re_before), 32'd0);
        applyStimulus(600, 1500);
        checkOutput("after rst width", width, 32'd600);
        checkOutput("after rst lost", {31'd0, signal_lost}, 32'd0);

        // Input stops low after valid frames.
        $display("[TB] signal stops low");
        applyStimulus(800, 2000);
        checkOutput("800 width", width, 32'd800);
        pwm_in = 1'b1;
        repeat (800) @(negedge clock);
        pwm_in = 1'b0;
        repeat (TO - 10) @(negedge clock);
        checkOutput("low not yet lost", {31'd0, signal_lost}, 32'd0);
        repeat (20) @(negedge clock);
        checkOutput("low lost", {31'd0, signal_lost}, 32'd1);
        checkOutput("low width held", width, 32'd800);
        applyStimulus(850, 1500);
        checkOutput("recover width", width, 32'd850);
        checkOutput("recover lost", {31'd0, signal_lost}, 32'd0);

        // Input stuck high for 20000 cycles.
        $display("[TB] signal stuck high");
        snapshot();
        pwm_in = 1'b1;
        repeat (TO - 10) @(negedge clock);
        checkOutput("high not yet lost", {31'd0, signal_lost}, 32'd0);
        repeat (30) @(negedge clock);
        checkOutput("high lost", {31'd0, signal_lost}, 32'd1);
        repeat (20000 - TO - 20) @(negedge clock);
        pwm_in = 1'b0;
        repeat (1500) @(negedge clock);
        checkOutput("stuck no valid", 32'(wv_count - wv_before), 32'd0);
        checkOutput("stuck no error", 32'(re_count - re_before), 32'd0);
        checkOutput("stuck width held", width, 32'd850);
        applyStimulus(700, 1500);
        checkOutput("post stuck width", width, 32'd700);
        checkOutput("post stuck lost", {31'd0, signal_lost}, 32'd0);

        checkOutput("valid/error exclusive", 32'(both_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
